// File: rtl/pwrseq_dev_grp_seq.sv
// Staggered power sequencer: brings device groups up in ascending order and
// down in descending order, latching pgood-timeout and group faults.
module pwrseq_dev_grp_seq #(
    parameter int NUM_GRP    = 4,
    parameter int STAGGER_US = 100,
    parameter int PGD_TMO_US = 20000,
    parameter int OFF_US     = 500
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               t1us,
    input  logic               pwr_req,
    input  logic               fault_clear,
    input  logic [NUM_GRP-1:0] grp_pgd_so_far,
    input  logic [NUM_GRP-1:0] grp_mod_fault,
    output logic [NUM_GRP-1:0] grp_gate_en,
    output logic               all_on,
    output logic               all_off,
    output logic               seq_fault,
    output logic [3:0]         fault_grp,
    output logic               fault_tmo
);

    localparam int MAXA = (STAGGER_US > PGD_TMO_US) ? STAGGER_US : PGD_TMO_US;
    localparam int MAXV = (MAXA > OFF_US) ? MAXA : OFF_US;
    localparam int CW   = $clog2(MAXV + 1);

    localparam logic [CW-1:0] STG_C   = CW'(STAGGER_US);
    localparam logic [CW-1:0] TMO_C   = CW'(PGD_TMO_US);
    localparam logic [CW-1:0] OFF_C   = CW'(OFF_US);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [3:0]    LAST    = 4'(NUM_GRP - 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_ON_WAIT,
        S_STAGGER,
        S_ON_DONE,
        S_OFF_SEQ,
        S_FAULT
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_GRP-1:0] gate_en_q, gate_en_d;
    logic               all_on_q, all_on_d;
    logic               all_off_q, all_off_d;
    logic               seq_fault_q, seq_fault_d;
    logic [3:0]         fault_grp_q, fault_grp_d;
    logic               fault_tmo_q, fault_tmo_d;

    logic [NUM_GRP-1:0] idx_oh;
    logic [NUM_GRP-1:0] flt_vec;
    logic [3:0]         flt_low;
    logic               flt_any;
    logic               pgd_idx;
    logic               restart;
    logic               enter_flt;
    logic               flt_is_tmo;

    assign idx_oh  = NUM_GRP'(1) << idx_q;
    assign pgd_idx = |(grp_pgd_so_far & idx_oh);
    // Only enabled groups may raise a fault.
    assign flt_vec = grp_mod_fault & gate_en_q;
    assign flt_any = |flt_vec;

    always_comb begin
        flt_low = '0;
        for (int k = NUM_GRP - 1; k >= 0; k--) begin
            if (flt_vec[k]) flt_low = 4'(k);
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gate_en_d   = gate_en_q;
        seq_fault_d = seq_fault_q;
        fault_grp_d = fault_grp_q;
        fault_tmo_d = fault_tmo_q;
        restart     = 1'b0;
        enter_flt   = 1'b0;
        flt_is_tmo  = 1'b0;

        if (fault_clear && !pwr_req && seq_fault_q) begin
            seq_fault_d = 1'b0;
            fault_grp_d = '0;
            fault_tmo_d = 1'b0;
        end

        unique case (state_q)
            S_OFF: begin
                if (pwr_req && !seq_fault_q) begin
                    state_d   = S_ON_WAIT;
                    idx_d     = '0;
                    gate_en_d = NUM_GRP'(1);
                end
            end
            S_ON_WAIT: begin
                if (flt_any) begin
                    enter_flt = 1'b1;
                end else if (!pwr_req) begin
                    state_d   = S_OFF_SEQ;
                    gate_en_d = gate_en_q & ~idx_oh;
                end else if (pgd_idx) begin
                    state_d = (idx_q == LAST) ? S_ON_DONE : S_STAGGER;
                end else if (cnt_q >= TMO_C) begin
                    enter_flt  = 1'b1;
                    flt_is_tmo = 1'b1;
                end
            end
            S_STAGGER: begin
                if (flt_any) begin
                    enter_flt = 1'b1;
                end else if (!pwr_req) begin
                    state_d   = S_OFF_SEQ;
                    gate_en_d = gate_en_q & ~idx_oh;
                end else if (cnt_q >= STG_C) begin
                    state_d   = S_ON_WAIT;
                    idx_d     = idx_q + 4'd1;
                    gate_en_d = gate_en_q | (idx_oh << 1);
                end
            end
            S_ON_DONE: begin
                if (flt_any) begin
                    enter_flt = 1'b1;
                end else if (!pwr_req) begin
                    state_d   = S_OFF_SEQ;
                    gate_en_d = gate_en_q & ~idx_oh;
                end
            end
            S_OFF_SEQ: begin
                if (flt_any) begin
                    enter_flt = 1'b1;
                end else if (cnt_q >= OFF_C) begin
                    if (idx_q == 4'd0) begin
                        state_d = S_OFF;
                    end else begin
                        // Next lower group: drop it and restart the delay.
                        idx_d     = idx_q - 4'd1;
                        gate_en_d = gate_en_q & ~(idx_oh >> 1);
                        restart   = 1'b1;
                    end
                end
            end
            S_FAULT: begin
                state_d = S_OFF;
            end
            default: begin
                state_d = S_OFF;
            end
        endcase

        if (enter_flt) begin
            state_d     = S_FAULT;
            gate_en_d   = '0;
            seq_fault_d = 1'b1;
            fault_tmo_d = flt_is_tmo;
            fault_grp_d = flt_is_tmo ? idx_q : flt_low;
        end

        if (state_d != state_q) restart = 1'b1;

        if (restart) begin
            cnt_d = '0;
        end else if (t1us && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        all_on_d  = (state_d == S_ON_DONE) && (&grp_pgd_so_far);
        all_off_d = (state_d == S_OFF);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_OFF;
            idx_q       <= '0;
            cnt_q       <= '0;
            gate_en_q   <= '0;
            all_on_q    <= 1'b0;
            all_off_q   <= 1'b1;
            seq_fault_q <= 1'b0;
            fault_grp_q <= '0;
            fault_tmo_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            gate_en_q   <= gate_en_d;
            all_on_q    <= all_on_d;
            all_off_q   <= all_off_d;
            seq_fault_q <= seq_fault_d;
            fault_grp_q <= fault_grp_d;
            fault_tmo_q <= fault_tmo_d;
        end
    end

    assign grp_gate_en = gate_en_q;
    assign all_on      = all_on_q;
    assign all_off     = all_off_q;
    assign seq_fault   = seq_fault_q;
    assign fault_grp   = fault_grp_q;
    assign fault_tmo   = fault_tmo_q;

endmodule
